// File: rtl/rx_pkg.sv
// Shared constants and width helpers for the receive bit-timing slice.
package rx_pkg;

    localparam int CLKS_PER_BIT_DEF  = 8;
    localparam int SAMPLE_PHASE_DEF  = 2;
    localparam int BITS_PER_BYTE_DEF = 8;
    localparam int STUFF_RUN_DEF     = 6;

    // Widths never drop below one bit so degenerate parameters still elaborate.
    function automatic int phase_width(input int clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

    function automatic int count_width(input int bits_per_byte);
        return (bits_per_byte > 1) ? $clog2(bits_per_byte) : 1;
    endfunction

    function automatic int run_width(input int stuff_run);
        return (stuff_run > 0) ? $clog2(stuff_run + 1) : 1;
    endfunction

endpackage

// File: rtl/rx_stuff_detect.sv
// Tracks the run of consecutive sampled 1s and flags the bit that follows a full run
// as a stuff bit; a 1 in that position is a stuff error.
module rx_stuff_detect
    import rx_pkg::*;
#(
    parameter int STUFF_EN  = 1,
    parameter int STUFF_RUN = STUFF_RUN_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic sample,
    input  logic d_bit,
    output logic is_stuff,
    output logic stuff_error
);

    localparam int RW = run_width(STUFF_RUN);

    generate
        if (STUFF_EN != 0) begin : g_stuff
            logic [RW-1:0] ones_run;
            logic          at_run;

            assign at_run      = (ones_run == RW'(STUFF_RUN));
            assign is_stuff    = sample && at_run;
            assign stuff_error = is_stuff && d_bit;

            // The run spans byte boundaries; only a 0, a stuff bit or leaving receive clears it.
            always_ff @(posedge clk) begin
                if (reset || clear) begin
                    ones_run <= '0;
                end else if (sample) begin
                    if (at_run || !d_bit) begin
                        ones_run <= '0;
                    end else begin
                        ones_run <= ones_run + 1'b1;
                    end
                end
            end
        end else begin : g_no_stuff
            logic unused_inputs;
            assign unused_inputs = ^{clk, reset, clear, sample, d_bit};
            assign is_stuff      = 1'b0;
            assign stuff_error   = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/rx_bit_timer.sv
// Receive bit timer: tracks bit phase, resynchronises on data edges, issues one
// sample/shift strobe per bit, counts bits into bytes and removes stuff bits.
module rx_bit_timer
    import rx_pkg::*;
#(
    parameter int CLKS_PER_BIT  = CLKS_PER_BIT_DEF,
    parameter int SAMPLE_PHASE  = SAMPLE_PHASE_DEF,
    parameter int BITS_PER_BYTE = BITS_PER_BYTE_DEF,
    parameter int STUFF_EN      = 1,
    parameter int STUFF_RUN     = STUFF_RUN_DEF
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  d_edge,
    input  logic                                  rcving,
    input  logic                                  d_bit,
    output logic                                  shift_enable,
    output logic                                  byte_received,
    output logic [count_width(BITS_PER_BYTE)-1:0] bit_count,
    output logic                                  stuff_skip,
    output logic                                  stuff_error
);

    localparam int PW = phase_width(CLKS_PER_BIT);
    localparam int CW = count_width(BITS_PER_BYTE);

    logic [PW-1:0] phase;
    logic [CW-1:0] bit_cnt;
    logic          active;
    logic          sample;
    logic          is_stuff;
    logic          last_bit;

    // Gating with reset keeps every output quiet while reset is asserted.
    assign active        = rcving && !reset;
    assign sample        = active && !d_edge && (phase == PW'(SAMPLE_PHASE));
    assign last_bit      = (bit_cnt == CW'(BITS_PER_BYTE - 1));
    assign shift_enable  = sample && !is_stuff;
    assign byte_received = shift_enable && last_bit;
    assign stuff_skip    = is_stuff;
    assign bit_count     = active ? bit_cnt : '0;

    rx_stuff_detect #(
        .STUFF_EN  (STUFF_EN),
        .STUFF_RUN (STUFF_RUN)
    ) u_stuff_detect (
        .clk         (clk),
        .reset       (reset),
        .clear       (!rcving),
        .sample      (sample),
        .d_bit       (d_bit),
        .is_stuff    (is_stuff),
        .stuff_error (stuff_error)
    );

    // Phase wraps explicitly so non-power-of-two bit periods stay exact.
    always_ff @(posedge clk) begin
        if (reset || !rcving) begin
            phase <= '0;
        end else if (d_edge || (phase == PW'(CLKS_PER_BIT - 1))) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !rcving) begin
            bit_cnt <= '0;
        end else if (shift_enable) begin
            bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        end
    end

endmodule

// File: doc/rx_bit_timer.md
Name: rx_bit_timer

Overview:
Parametrised receive bit-timing block for the serial receiver front end. It tracks bit phase from the receiver's edge detector, issues one sample/shift strobe per bit period, and resynchronises on every data edge. It also counts bits into bytes and handles NRZI bit-stuff removal and stuff-error detection. It sits between the edge detector / decoder and the RX shift register and RX control FSM.

Parameters:
CLKS_PER_BIT, 8, clock cycles per bit period (min 4)
SAMPLE_PHASE, 2, phase value at which a bit is sampled (1 to CLKS_PER_BIT-1)
BITS_PER_BYTE, 8, data bits per byte_received (min 2)
STUFF_EN, 1, 1 enables bit-stuff removal; 0 disables it (stuff outputs tied 0)
STUFF_RUN, 6, consecutive sampled 1s after which the next bit is a stuff bit

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous active-high reset
d_edge  input  1  single-cycle pulse from edge detector, data line transition
rcving  input  1  high while a packet is being received
d_bit  input  1  decoded bit value, valid in sample cycles
shift_enable  output  1  one-cycle strobe: shift d_bit into RX shift register
byte_received  output  1  one-cycle strobe coincident with the last data bit's shift_enable
bit_count  output  $clog2(BITS_PER_BYTE)  data bits accepted in the current byte
stuff_skip  output  1  one-cycle strobe: current sample is a stuff bit and was discarded
stuff_error  output  1  one-cycle strobe: stuff bit position held 1

Behaviour:
- Registers: phase (0..CLKS_PER_BIT-1), ones_run (0..STUFF_RUN), bit_cnt (0..BITS_PER_BYTE-1).
- Reset: synchronous, clk and reset only; no asynchronous reset anywhere. reset=1 clears all registers to 0. Every output is 0 during reset and in the cycle after it.
- Idle (rcving=0): all registers are cleared to 0 each cycle. All outputs are 0. d_edge is ignored.
- Phase, when rcving=1:
  - If d_edge=1, next phase=0.
  - Otherwise phase increments and wraps CLKS_PER_BIT-1 -> 0.
- Sample cycle: rcving=1, d_edge=0 and phase==SAMPLE_PHASE.
  - d_edge in the sample cycle wins: phase reloads to 0 and no sample occurs that cycle.
- Latency:
  - First sample is SAMPLE_PHASE cycles after the first rcving=1 cycle.
  - After a d_edge at cycle t, the sample is at t+1+SAMPLE_PHASE.
  - Without edges, samples repeat every CLKS_PER_BIT cycles.
- Outputs are combinational decodes of registered state plus rcving and d_bit. They never depend on d_edge except through the sample-cycle qualification.
- Stuff detection (STUFF_EN=1), evaluated in a sample cycle:
  - ones_run==STUFF_RUN: stuff bit.
    - stuff_skip=1, shift_enable=0, ones_run<=0, bit_cnt unchanged.
    - stuff_error=1 additionally if d_bit==1.
  - Otherwise: shift_enable=1.
    - ones_run <= d_bit ? ones_run+1 : 0.
    - bit_cnt <= (bit_cnt==BITS_PER_BYTE-1) ? 0 : bit_cnt+1.
    - byte_received=1 iff bit_cnt==BITS_PER_BYTE-1.
- STUFF_EN=0: every sample cycle gives shift_enable. stuff_skip and stuff_error stay 0. ones_run is unused.
- The stuff run counter spans byte boundaries; it is cleared only by a 0 bit, a stuff bit, rcving=0 or reset.
- rcving falling mid-byte: the partial byte is discarded, bit_cnt is cleared and no byte_received is issued.
- bit_count shows the registered bit_cnt value.
- No width overflow: phase is $clog2(CLKS_PER_BIT) bits and wraps explicitly, not by natural overflow.

Decomposition:
- Shared package rx_pkg holds:
  - default constants: CLKS_PER_BIT_DEF=8, SAMPLE_PHASE_DEF=2, BITS_PER_BYTE_DEF=8, STUFF_RUN_DEF=6;
  - derived width functions for phase and bit_cnt.
- One sub-module, rx_stuff_detect:
  - contains the ones_run counter;
  - inputs: clk, reset, clear (=!rcving), sample, d_bit;
  - outputs: is_stuff, stuff_error.
- The phase and byte counters stay inline.

Test Plan:
Defaults used unless stated.
1. reset=1 for 3 cycles with rcving=1 and d_edge pulsing -> all outputs 0; bit_count=0 the cycle after reset drops.
2. rcving=1 from cycle 10, no edges, d_bit alternating 0/1 -> shift_enable at cycles 12,20,...,68; byte_received only at 68; bit_count returns 0 at 69.
3. rcving=1 from cycle 10, d_edge at cycle 15 -> shift_enable at 12 and 18 (not 20), then 26; d_edge exactly at sample cycle 26 -> no strobe at 26, next at 29.
4. Six samples with d_bit=1, seventh with d_bit=0 -> seventh: stuff_skip=1, shift_enable=0, bit_count unchanged; eighth sample is a normal shift. Repeat with STUFF_EN=0 -> seventh is a normal shift.
5. Six 1s, seventh d_bit=1 -> stuff_skip=1 and stuff_error=1 same cycle, no shift_enable.
6. rcving dropped after 5 shifts, raised again 4 cycles later -> bit_count 0, no byte_received; next byte needs 8 fresh shifts. Same with reset pulse mid-byte.
7. CLKS_PER_BIT=5, SAMPLE_PHASE=4, BITS_PER_BYTE=4 -> strobes every 5 cycles, byte_received on every 4th.
